spi_ram_ctrl: RTL and testbench

Parametrised single-port RAM with the SPI slave's 2-bit command framing: each received word carries a command in its two MSBs and a payload below. Sits behind the SPI slave's receive path (rx_valid, din) and feeds read data back to its transmit path (tx_valid, dout). Over the fixed 256x8 RAM it adds:
- configurable data/address width and depth;
- independent write and read address pointers with optional auto-increment and wrap;
- a configurable read latency of 1 or 2 cycles, pipelined for back-to-back reads.

---
 rtl/spi_ram_ctrl.sv | 123 ++++++++++++
 tb/tb_spi_ram_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Command-framed single-port RAM behind an SPI slave: 2-bit command in the MSBs of each
// received word, independent write/read pointers, and a 1- or 2-cycle pipelined read path.
module spi_ram_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int MEM_DEPTH    = 256,
    parameter int AUTO_INC     = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH+1:0] din,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int LP_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH still fits the compare.
    localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("spi_ram_ctrl: READ_LATENCY must be 1 or 2, got %0d", READ_LATENCY);
    end
    if (ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
        $error("spi_ram_ctrl: ADDR_WIDTH must not exceed DATA_WIDTH");
    end
    if (MEM_DEPTH < 2 || MEM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("spi_ram_ctrl: MEM_DEPTH must lie in 2..2**ADDR_WIDTH");
    end

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] p);
        return ({1'b0, p} <= LP_LAST);
    endfunction

    // Wraps from the last word and from any out-of-range pointer back to 0.
    function automatic logic [ADDR_WIDTH-1:0] f_next_ptr(input logic [ADDR_WIDTH-1:0] p);
        if ({1'b0, p} >= LP_LAST) return '0;
        return p + ADDR_WIDTH'(1);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_dout;

    cmd_t                  w_cmd;
    logic                  w_exec;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_vld_out;
    logic [DATA_WIDTH-1:0] w_out_data;

    assign w_cmd     = cmd_t'(din[DATA_WIDTH+1:DATA_WIDTH]);
    assign w_exec    = rx_valid && !rst;
    assign w_wr_en   = w_exec && (w_cmd == CMD_WR_DATA) && f_in_range(r_wr_ptr);
    assign w_rd_en   = w_exec && (w_cmd == CMD_RD_DATA);
    assign w_rd_data = f_in_range(r_rd_ptr) ? r_mem[r_rd_ptr[LP_IDX_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_exec) begin
            case (w_cmd)
                CMD_WR_ADDR: r_wr_ptr <= din[ADDR_WIDTH-1:0];
                CMD_WR_DATA: if (AUTO_INC != 0) r_wr_ptr <= f_next_ptr(r_wr_ptr);
                CMD_RD_ADDR: r_rd_ptr <= din[ADDR_WIDTH-1:0];
                CMD_RD_DATA: if (AUTO_INC != 0) r_rd_ptr <= f_next_ptr(r_rd_ptr);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[LP_IDX_W-1:0]] <= din[DATA_WIDTH-1:0];
    end

    // Stage p0: array read registered ahead of the output register.
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_vld_p0;
        logic [DATA_WIDTH-1:0] r_rdata_p0;

        always_ff @(posedge clk) begin
            if (w_rd_en) r_rdata_p0 <= w_rd_data;
        end

        always_ff @(posedge clk) begin
            if (rst) r_vld_p0 <= 1'b0;
            else     r_vld_p0 <= w_rd_en;
        end

        assign w_vld_out  = r_vld_p0;
        assign w_out_data = r_rdata_p0;
    end else begin : g_lat1
        assign w_vld_out  = w_rd_en;
        assign w_out_data = w_rd_data;
    end

    // Output stage: tx_valid pulses once per read, dout holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_tx_valid <= w_vld_out;
            if (w_vld_out) r_dout <= w_out_data;
        end
    end

    assign tx_valid = r_tx_valid;
    assign dout     = r_dout;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench: four configurations share one stimulus stream and are compared
// every cycle against a per-configuration behavioural model of the command rules.
module tb_spi_ram_ctrl;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_valid = 1'b0;
    logic [9:0]       din = '0;
    logic [3:0]       txv;
    logic [3:0][7:0]  dq;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1), .READ_LATENCY(1))
        u_def (.clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .tx_valid(txv[0]), .dout(dq[0]));
    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1), .READ_LATENCY(1))
        u_wrap (.clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .tx_valid(txv[1]), .dout(dq[1]));
    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0), .READ_LATENCY(1))
        u_static (.clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .tx_valid(txv[2]), .dout(dq[2]));
    spi_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1), .READ_LATENCY(2))
        u_lat2 (.clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .tx_valid(txv[3]), .dout(dq[3]));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, one slot per configuration.
    int         depth [4] = '{256, 200, 256, 256};
    int         inc   [4] = '{1, 1, 0, 1};
    int         lat   [4] = '{1, 1, 1, 2};
    int         wp [4];
    int         rp [4];
    logic [7:0] mm [4][256];
    bit         ev [4];
    logic [7:0] ed [4];
    bit         pv [4];
    logic [7:0] pd [4];

    bit         cap_on  = 1'b0;
    int         cap_sel = 0;
    logic [7:0] qa0 [$];
    logic [7:0] qa3 [$];
    logic [7:0] qb0 [$];
    logic [7:0] qb3 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [9:0] d);
        logic [1:0] c;
        int         pl;
        logic [7:0] val;
        c  = d[9:8];
        pl = int'(d[7:0]);
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                wp[k] = 0; rp[k] = 0; ev[k] = 1'b0; ed[k] = 8'h00; pv[k] = 1'b0;
            end else begin
                ev[k] = pv[k];
                if (pv[k]) ed[k] = pd[k];
                pv[k] = 1'b0;
                if (v) begin
                    case (c)
                        2'b00: wp[k] = pl;
                        2'b01: begin
                            if (wp[k] < depth[k]) mm[k][wp[k]] = d[7:0];
                            if (inc[k] != 0) wp[k] = (wp[k] >= depth[k] - 1) ? 0 : wp[k] + 1;
                        end
                        2'b10: rp[k] = pl;
                        default: begin
                            val = (rp[k] < depth[k]) ? mm[k][rp[k]] : 8'h00;
                            if (lat[k] == 1) begin ev[k] = 1'b1; ed[k] = val; end
                            else             begin pv[k] = 1'b1; pd[k] = val; end
                            if (inc[k] != 0) rp[k] = (rp[k] >= depth[k] - 1) ? 0 : rp[k] + 1;
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [9:0] d);
        @(negedge clk);
        rst = r; rx_valid = v; din = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tx_valid[%0d]", k), 32'(txv[k]), 32'(ev[k]));
            chk($sformatf("dout[%0d]", k), 32'(dq[k]), 32'(ed[k]));
        end
        chk("def_wr_ptr", 32'(u_def.r_wr_ptr), 32'(wp[0]));
        chk("def_rd_ptr", 32'(u_def.r_rd_ptr), 32'(rp[0]));
        chk("wrap_wr_ptr", 32'(u_wrap.r_wr_ptr), 32'(wp[1]));
        chk("wrap_rd_ptr", 32'(u_wrap.r_rd_ptr), 32'(rp[1]));
        if (cap_on) begin
            if (cap_sel == 0) begin
                if (txv[0]) qa0.push_back(dq[0]);
                if (txv[3]) qa3.push_back(dq[3]);
            end else begin
                if (txv[0]) qb0.push_back(dq[0]);
                if (txv[3]) qb3.push_back(dq[3]);
            end
        end
    endtask

    task automatic cmd(input logic [1:0] c, input logic [7:0] p);
        step(1'b0, 1'b1, {c, p});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 10'($urandom));
    endtask

    initial begin
        logic [7:0] pre0;
        logic [7:0] s6;
        logic [7:0] d1, d2, d3, d4;
        logic [9:0] seq [12];

        for (int k = 0; k < 4; k++) begin
            wp[k] = 0; rp[k] = 0; ev[k] = 1'b0; ed[k] = 8'h00; pv[k] = 1'b0; pd[k] = 8'h00;
        end
        for (int i = 0; i < 256; i++) begin
            mm[0][i] = 8'($urandom); u_def.r_mem[i]    = mm[0][i];
            mm[1][i] = 8'($urandom);
            mm[2][i] = 8'($urandom); u_static.r_mem[i] = mm[2][i];
            mm[3][i] = 8'($urandom); u_lat2.r_mem[i]   = mm[3][i];
        end
        for (int i = 0; i < 200; i++) u_wrap.r_mem[i] = mm[1][i];
        pre0 = mm[0][0];

        // Reset held with a read command present: nothing may come out.
        step(1'b1, 1'b1, {2'b11, 8'($urandom)});
        step(1'b1, 1'b1, {2'b11, 8'($urandom)});
        chk("rst_tx_valid", 32'(txv), 32'h0);
        chk("rst_dout", 32'(dq), 32'h0);
        cmd(2'b11, 8'h00);
        chk("rst_then_rd0_vld", 32'(txv[0]), 32'h1);
        chk("rst_then_rd0", 32'(dq[0]), 32'(pre0));

        // Burst write then burst read.
        cmd(2'b00, 8'h10);
        cmd(2'b01, 8'hA1); cmd(2'b01, 8'hA2); cmd(2'b01, 8'hA3);
        cmd(2'b10, 8'h10);
        cmd(2'b11, 8'h00); chk("burst0_vld", 32'(txv[0]), 32'h1); chk("burst0", 32'(dq[0]), 32'hA1);
        cmd(2'b11, 8'h00); chk("burst1_vld", 32'(txv[0]), 32'h1); chk("burst1", 32'(dq[0]), 32'hA2);
        cmd(2'b11, 8'h00); chk("burst2_vld", 32'(txv[0]), 32'h1); chk("burst2", 32'(dq[0]), 32'hA3);
        idle();            chk("burst_end", 32'(txv[0]), 32'h0);

        // Static pointers.
        s6 = mm[2][6];
        cmd(2'b00, 8'h05); cmd(2'b01, 8'h11); cmd(2'b01, 8'h22); cmd(2'b10, 8'h05);
        cmd(2'b11, 8'h00); chk("static_rd0", 32'(dq[2]), 32'h22);
        cmd(2'b11, 8'h00); chk("static_rd1", 32'(dq[2]), 32'h22);
        chk("static_vld", 32'(txv[2]), 32'h1);
        chk("static_mem6", 32'(u_static.r_mem[6]), 32'(s6));

        // Wrap at depth 200, out-of-range read and write.
        cmd(2'b00, 8'hC7); cmd(2'b01, 8'h55); cmd(2'b01, 8'h66);
        chk("wrap_mem199", 32'(u_wrap.r_mem[199]), 32'h55);
        chk("wrap_mem0", 32'(u_wrap.r_mem[0]), 32'h66);
        cmd(2'b10, 8'hC8); cmd(2'b11, 8'h00);
        chk("oor_rd_vld", 32'(txv[1]), 32'h1);
        chk("oor_rd_data", 32'(dq[1]), 32'h0);
        cmd(2'b00, 8'hC8); cmd(2'b01, 8'h77);
        chk("oor_wr_ptr_wrap", 32'(u_wrap.r_wr_ptr), 32'h0);
        chk("oor_wr_mem0", 32'(u_wrap.r_mem[0]), 32'h66);
        chk("oor_wr_mem199", 32'(u_wrap.r_mem[199]), 32'h55);

        // Two-cycle latency and reset during an in-flight read.
        cmd(2'b11, 8'h00); chk("lat2_n", 32'(txv[3]), 32'h0);
        idle();            chk("lat2_n1", 32'(txv[3]), 32'h1);
        idle();            chk("lat2_n2", 32'(txv[3]), 32'h0);
        cmd(2'b11, 8'h00);
        step(1'b1, 1'b0, 10'h0); chk("lat2_rst_n1", 32'(txv[3]), 32'h0);
        idle();                  chk("lat2_rst_n2", 32'(txv[3]), 32'h0);
        idle();                  chk("lat2_rst_n3", 32'(txv[3]), 32'h0);

        // Same command list with and without idle gaps must read back identically.
        d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom); d4 = 8'($urandom);
        seq = '{{2'b00, 8'h30}, {2'b01, d1}, {2'b01, d2}, {2'b01, d3}, {2'b01, d4},
                {2'b10, 8'h30}, {2'b11, 8'h00}, {2'b11, 8'h00}, {2'b11, 8'h00}, {2'b11, 8'h00},
                {2'b10, 8'h31}, {2'b11, 8'h00}};
        cap_on = 1'b1; cap_sel = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, seq[i]);
        idle(); idle();
        cap_sel = 1;
        for (int i = 0; i < 12; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) idle();
            step(1'b0, 1'b1, seq[i]);
        end
        idle(); idle();
        cap_on = 1'b0;
        chk("gapfree_count", 32'(qa0.size()), 32'd5);
        chk("gap_count", 32'(qb0.size()), 32'd5);
        chk("gap_count_lat2", 32'(qb3.size()), 32'(qa3.size()));
        if (qa0.size() == 5) begin
            chk("gapfree_rd0", 32'(qa0[0]), 32'(d1));
            chk("gapfree_rd3", 32'(qa0[3]), 32'(d4));
            chk("gapfree_rd4", 32'(qa0[4]), 32'(d2));
        end
        for (int i = 0; i < qa0.size() && i < qb0.size(); i++)
            chk($sformatf("gap_vs_gapfree[%0d]", i), 32'(qb0[i]), 32'(qa0[i]));
        for (int i = 0; i < qa3.size() && i < qb3.size(); i++)
            chk($sformatf("gap_vs_gapfree_lat2[%0d]", i), 32'(qb3[i]), 32'(qa3[i]));

        // Randomized commands, idle gaps and occasional resets.
        for (int n = 0; n < 400; n++) begin
            bit         r;
            bit         v;
            logic [7:0] pl;
            r  = ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 2) != 0);
            pl = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(192, 207));
            step(r, v, {2'($urandom), pl});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
